// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_ctrl_pkg
//  Description : Shared types, default constants and the byte-address to
//                word-index helper for the MEM-stage access controller.
//  Contents    :
//                mac_state_t  - IDLE / BUSY / DONE controller states
//                mac_idx_t    - word index plus in-range flag
//                word_idx()   - (addr - base) >> 2 with range check
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_ctrl_pkg;

    // Default memory map: word 0 lives at byte address 1024, 64 words deep.
    localparam int unsigned c_BASE_ADDR_DEF = 1024;
    localparam int unsigned c_DEPTH_DEF     = 64;
    localparam int unsigned c_IDX_W_DEF     = 6;
    localparam int unsigned c_TIMEOUT_DEF   = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mac_state_t;

    // Full 30-bit word offset is kept so the caller can truncate to its own
    // index width; in_range already accounts for the upper bits.
    typedef struct packed {
        logic        in_range;
        logic [29:0] idx;
    } mac_idx_t;

    // Unsigned 32-bit subtract; an address below base wraps to a huge offset,
    // but it is rejected explicitly so the wrap never aliases into range.
    function automatic mac_idx_t word_idx(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [31:0] depth
    );
        mac_idx_t    res;
        logic [31:0] offs;
        offs         = addr - base;
        res.idx      = offs[31:2];
        res.in_range = (addr >= base) && ((offs >> 2) < depth);
        return res;
    endfunction

endpackage : mem_ctrl_pkg
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_ctrl
//  Description : MEM-stage initiator for a word-addressed data memory.
//                Converts the pipeline's load/store request into a req/ack
//                bus transaction, freezes the pipeline (ready=0) until the
//                access completes, and returns load data on data_mem.
//  Ports       :
//    clk, rst              clock / synchronous active-high reset
//    MEM_R_EN, MEM_W_EN    load / store request (held while ready=0)
//    alu_res               byte address
//    rm_val                store data
//    data_mem              registered load result (0 for stores/errors)
//    ready                 1 = pipeline may advance
//    acc_err               sticky out-of-range / timeout flag
//    mem_req, mem_we,
//    mem_addr, mem_wdata   bus request side, stable while mem_req=1
//    mem_ack, mem_rdata    bus completion pulse and read data
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned BASE_ADDR = c_BASE_ADDR_DEF,
    parameter int unsigned DEPTH     = c_DEPTH_DEF,
    parameter int unsigned IDX_W     = c_IDX_W_DEF,
    parameter int unsigned TIMEOUT   = c_TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             MEM_R_EN,
    input  logic             MEM_W_EN,
    input  logic [31:0]      alu_res,
    input  logic [31:0]      rm_val,
    output logic [31:0]      data_mem,
    output logic             ready,
    output logic             acc_err,
    output logic             mem_req,
    output logic             mem_we,
    output logic [IDX_W-1:0] mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic             mem_ack,
    input  logic [31:0]      mem_rdata
);

    // Wait counter counts 0..TIMEOUT-1 inside BUSY.
    localparam int unsigned   c_CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    mac_state_t         state_q;
    logic [31:0]        data_mem_q;
    logic               acc_err_q;
    logic               mem_req_q;
    logic               mem_we_q;
    logic [IDX_W-1:0]   mem_addr_q;
    logic [31:0]        mem_wdata_q;
    logic [c_CNT_W-1:0] cnt_q;

    mac_idx_t           w_widx;
    logic               w_access;
    logic [IDX_W-1:0]   w_idx;

    assign w_widx   = word_idx(alu_res, 32'(BASE_ADDR), 32'(DEPTH));
    assign w_idx    = IDX_W'(w_widx.idx);
    assign w_access = MEM_R_EN | MEM_W_EN;

    // ready is combinational so an idle pipeline never loses a cycle; it is
    // only low while a request is pending in IDLE or the bus is busy.
    assign ready = ((state_q == IDLE) && !w_access) || (state_q == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            data_mem_q  <= '0;
            acc_err_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cnt_q       <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (w_access) begin
                        if (w_widx.in_range) begin
                            // Write wins when both enables are asserted.
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= MEM_W_EN;
                            mem_addr_q  <= w_idx;
                            mem_wdata_q <= rm_val;
                            cnt_q       <= '0;
                            state_q     <= BUSY;
                        end else begin
                            // Illegal address: flag it and release the
                            // pipeline without touching the bus.
                            acc_err_q  <= 1'b1;
                            data_mem_q <= '0;
                            state_q    <= DONE;
                        end
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        mem_req_q  <= 1'b0;
                        data_mem_q <= mem_we_q ? 32'd0 : mem_rdata;
                        state_q    <= DONE;
                    end else if (cnt_q == c_CNT_LAST) begin
                        // Ack never came: abandon the transaction.
                        mem_req_q  <= 1'b0;
                        acc_err_q  <= 1'b1;
                        data_mem_q <= '0;
                        state_q    <= DONE;
                    end else begin
                        cnt_q <= cnt_q + c_CNT_W'(1);
                    end
                end
                DONE: begin
                    // Pipeline advances on this edge; always return through
                    // IDLE so the next request is decoded from fresh inputs.
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign data_mem  = data_mem_q;
    assign acc_err   = acc_err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule : mem_access_ctrl
`default_nettype wire
